// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cacheline adaptor: the transaction state encoding and
// the default beat geometry (256-bit line carried as 64-bit beats).
package cacheline_adaptor_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int S_LINE_DFLT  = 256;
  localparam int S_BURST_DFLT = 64;
  localparam int BEATS        = S_LINE_DFLT / S_BURST_DFLT;
  localparam int CNT_W        = $clog2(BEATS);

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one cacheline read or writeback from the L1 cache
// into a burst of s_line/s_burst beats on the memory bus, then returns a
// single-cycle resp_o to the cache.
// Optional build macro CACHELINE_ADAPTOR_PROTO_CHK_EN adds a sticky
// proto_err_o flag for stray memory strobes and conflicting requests.
module cacheline_adaptor
  import cacheline_adaptor_types::*;
#(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
  ,
  output logic               proto_err_o
`endif
);

  localparam int n_beats = s_line / s_burst;
  localparam int cnt_w   = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);

  state_t            state;
  logic [cnt_w-1:0]  cnt;
  logic [s_line-1:0] buffer;
  logic [31:0]       addr_q;
  int                beat_lsb;

  // Memory always sees line-aligned addresses; the offset bits are dropped.
  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return {a[31:s_offset], {s_offset{1'b0}}};
  endfunction

  assign beat_lsb = int'(cnt) * s_burst;

  // Request capture, beat counting and line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Writeback wins over a simultaneous read request.
          if (write_i) begin
            buffer <= line_i;
            addr_q <= line_addr(address_i);
            state  <= WRITE;
          end else if (read_i) begin
            addr_q <= line_addr(address_i);
            state  <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            buffer[beat_lsb +: s_burst] <= burst_i;
            if (cnt == last_beat) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (cnt == last_beat) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // Requests still held during the response cycle are not re-accepted.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = (state == READ || state == WRITE) ? addr_q : 32'd0;
  assign burst_o   = (state == WRITE) ? buffer[beat_lsb +: s_burst] : '0;
  assign line_o    = buffer;

`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
  // Sticky flag: memory strobing with no burst open, or an ambiguous request
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_o <= 1'b0;
    end else if ((resp_i && (state == IDLE || state == DONE)) ||
                 (state == IDLE && read_i && write_i)) begin
      proto_err_o <= 1'b1;
    end
  end
`endif

endmodule
